uart_rx: RTL and testbench

UART receive stage that sits directly downstream of the baud-rate generator and consumes its oversampling tick.
- Synchronises the asynchronous serial line and detects the start bit.
- Samples each data, parity and stop bit at mid-bit using a 16x oversample tick.
- Presents each received byte on a valid/ready output register, with per-frame error flags.

---
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling on an oversample tick,
// valid/ready output register with per-frame parity/framing flags and sticky overrun.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] HalfCnt = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FullCnt = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LastBit = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } state_e;

  state_e               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [SW-1:0]        s_cnt;
  logic [BW-1:0]        b_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en;
  logic                 par_odd;
  logic                 p_err;
  logic                 mid_bit;

  assign mid_bit = sample_tick && (s_cnt == FullCnt);

  // Line idles high, so the synchroniser resets to 1 to avoid a spurious start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      s_cnt      <= '0;
      b_cnt      <= '0;
      shreg      <= '0;
      par_en     <= 1'b0;
      par_odd    <= 1'b0;
      p_err      <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (!rx_s) begin
            state   <= StStart;
            s_cnt   <= '0;
            par_en  <= parity_en;
            par_odd <= parity_odd;
          end
        end

        StStart: begin
          if (sample_tick) begin
            if (s_cnt == HalfCnt) begin
              if (!rx_s) begin
                state <= StData;
                s_cnt <= '0;
                b_cnt <= '0;
                p_err <= 1'b0;
              end else begin
                state <= StIdle;
              end
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end

        // s_cnt is a power-of-2 counter, so it wraps to 0 on the sampling tick.
        StData: begin
          if (sample_tick) begin
            s_cnt <= s_cnt + SW'(1);
          end
          if (mid_bit) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (b_cnt == LastBit) begin
              state <= par_en ? StParity : StStop;
            end else begin
              b_cnt <= b_cnt + BW'(1);
            end
          end
        end

        StParity: begin
          if (sample_tick) begin
            s_cnt <= s_cnt + SW'(1);
          end
          if (mid_bit) begin
            p_err <= ((^shreg) ^ rx_s) != par_odd;
            state <= StStop;
          end
        end

        StStop: begin
          if (sample_tick) begin
            s_cnt <= s_cnt + SW'(1);
          end
          if (mid_bit) begin
            // A consumer taking the old word this same cycle frees the register.
            if (!rx_valid || rx_ready) begin
              rx_data    <= shreg;
              parity_err <= p_err;
              frame_err  <= !rx_s;
              rx_valid   <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            state <= rx_s ? StIdle : StWaitHigh;
          end
        end

        StWaitHigh: begin
          if (rx_s) begin
            state <= StIdle;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame scenarios plus randomized frames
// checked against a popcount-based reference of the expected word and flags.
module tb_uart_rx;

  localparam int unsigned DataBits   = 8;
  localparam int unsigned Oversample = 16;
  localparam int unsigned TickDiv    = 4;
  localparam int unsigned BitClks    = Oversample * TickDiv;
  localparam int          Ticks8N1   = Oversample / 2 + Oversample * (DataBits + 1);

  logic                clk         = 1'b0;
  logic                rst         = 1'b1;
  logic                sample_tick = 1'b0;
  logic                rx          = 1'b1;
  logic                parity_en   = 1'b0;
  logic                parity_odd  = 1'b0;
  logic                rx_ready    = 1'b0;
  logic [DataBits-1:0] rx_data;
  logic                rx_valid;
  logic                parity_err;
  logic                frame_err;
  logic                overrun;

  int          n_tests     = 0;
  int          n_fail      = 0;
  int          valid_rises = 0;
  logic        valid_prev  = 1'b0;
  logic [9:0]  got_q[$];  // {frame_err, parity_err, rx_data}

  uart_rx #(
    .DATA_BITS (DataBits),
    .OVERSAMPLE(Oversample)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .rx         (rx),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    int unsigned div = 0;
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1) % TickDiv;
      sample_tick = (div == 0);
    end
  end

  // Record every accepted word and every rising edge of rx_valid.
  always @(negedge clk) begin
    if (rx_valid && !valid_prev) valid_rises++;
    valid_prev = rx_valid;
    if (rx_valid && rx_ready) got_q.push_back({frame_err, parity_err, rx_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 2000000", $time);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Parity inputs are scrambled after the start bit; the frame must use the values
  // present at the falling edge.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                            input logic pbit, input logic stop_bit, input int stop_extra);
    parity_en  = pen;
    parity_odd = podd;
    rx         = 1'b0;
    wait_clks(BitClks);
    parity_en  = 1'($urandom);
    parity_odd = 1'($urandom);
    for (int i = 0; i < DataBits; i++) begin
      rx = d[i];
      wait_clks(BitClks);
    end
    if (pen) begin
      rx = pbit;
      wait_clks(BitClks);
    end
    rx = stop_bit;
    wait_clks(BitClks + stop_extra);
    rx = 1'b1;
  endtask

  function automatic logic exp_perr(input logic [7:0] d, input logic pen, input logic podd,
                                    input logic pbit);
    int ones;
    if (!pen) return 1'b0;
    ones = $countones(d) + int'(pbit);
    return podd ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic perr,
                              input logic ferr);
    logic [9:0] f;
    check_eq({tag, ".count"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      f = got_q.pop_front();
      check_eq({tag, ".data"}, f[7:0], d);
      check_eq({tag, ".parity_err"}, f[8], perr);
      check_eq({tag, ".frame_err"}, f[9], ferr);
    end
    got_q.delete();
  endtask

  // Raise rx_ready only on the clock whose tick samples the stop bit.
  task automatic ready_on_stop_tick(input int ticks_to_stop);
    int ticks = 0;
    bit done  = 1'b0;
    repeat (3) @(posedge clk);
    for (int c = 0; c < 40 * BitClks && !done; c++) begin
      @(negedge clk);
      if (sample_tick) ticks++;
      if (ticks == ticks_to_stop) begin
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        done = 1'b1;
      end
    end
    check_eq("same_cycle.tick_found", done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".rx_valid"}, rx_valid, 0);
    check_eq({tag, ".rx_data"}, rx_data, 0);
    check_eq({tag, ".parity_err"}, parity_err, 0);
    check_eq({tag, ".frame_err"}, frame_err, 0);
    check_eq({tag, ".overrun"}, overrun, 0);
  endtask

  initial begin
    int          rises0;
    logic [7:0]  d;
    logic        pen, podd, pbit, stop;

    rst = 1'b1;
    wait_clks(3);
    check_all_zero("reset");
    rst = 1'b0;
    wait_clks(BitClks);

    // Plain 8N1 frame.
    rx_ready = 1'b1;
    rises0 = valid_rises;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    wait_clks(BitClks);
    expect_frame("a5", 8'hA5, 1'b0, 1'b0);
    check_eq("a5.pulses", valid_rises - rises0, 1);
    check_eq("a5.overrun", overrun, 0);

    // Parity: 0x3C has four ones.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    wait_clks(BitClks);
    expect_frame("even_bad", 8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    wait_clks(BitClks);
    expect_frame("even_ok", 8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    wait_clks(BitClks);
    expect_frame("odd_ok", 8'h3C, 1'b0, 1'b0);

    // Short low glitch is a false start.
    rises0 = valid_rises;
    rx = 1'b0;
    wait_clks(4 * TickDiv);
    rx = 1'b1;
    wait_clks(2 * BitClks);
    check_eq("glitch.pulses", valid_rises - rises0, 0);
    check_eq("glitch.frames", got_q.size(), 0);

    // Framing error followed by a held break, then a clean frame.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 3 * BitClks);
    wait_clks(BitClks);
    expect_frame("break", 8'h55, 1'b0, 1'b1);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    wait_clks(BitClks);
    expect_frame("after_break", 8'h12, 1'b0, 1'b0);

    // Overrun with the consumer stalled.
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    wait_clks(BitClks);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    wait_clks(BitClks);
    check_eq("ovr.rx_valid", rx_valid, 1);
    check_eq("ovr.rx_data", rx_data, 8'h11);
    check_eq("ovr.overrun", overrun, 1);
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
    check_eq("ovr_ack.rx_valid", rx_valid, 0);
    check_eq("ovr_ack.overrun", overrun, 0);
    got_q.delete();

    // Handshake on the completion clock: the new word loads, no overrun.
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    wait_clks(BitClks);
    check_eq("same_cycle.pre_data", rx_data, 8'h33);
    fork
      send_frame(8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      ready_on_stop_tick(Ticks8N1);
    join
    wait_clks(BitClks);
    check_eq("same_cycle.rx_data", rx_data, 8'h44);
    check_eq("same_cycle.rx_valid", rx_valid, 1);
    check_eq("same_cycle.overrun", overrun, 0);
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
    check_eq("same_cycle.ack", rx_valid, 0);
    got_q.delete();

    // Reset late in data bit 4 with an unread word pending.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    wait_clks(BitClks);
    check_eq("rst.pre_valid", rx_valid, 1);
    fork
      send_frame(8'hE7, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      begin
        wait_clks(5 * BitClks + 3 * BitClks / 4);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        wait_clks(4);
        rst = 1'b0;
        rises0 = valid_rises;
      end
    join
    wait_clks(2 * BitClks);
    check_eq("rst.no_frame", valid_rises - rises0, 0);
    got_q.delete();
    rx_ready = 1'b1;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    wait_clks(BitClks);
    expect_frame("post_rst", 8'h81, 1'b0, 1'b0);

    // Randomized frames against the reference.
    for (int i = 0; i < 20; i++) begin
      d    = 8'($urandom);
      pen  = 1'($urandom);
      podd = 1'($urandom);
      pbit = 1'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, pen, podd, pbit, stop, 0);
      wait_clks(BitClks / 2 + int'($urandom_range(0, BitClks)));
      expect_frame("rand", d, exp_perr(d, pen, podd, pbit), !stop);
      check_eq("rand.overrun", overrun, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
